// File: rtl/wb_rr_arbiter.sv
// Round-robin N-master to 1-slave WISHBONE classic arbiter; ownership is held for a whole cyc.
// Optional stalled-strobe watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rst_n_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]                m_dat_o,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic                                 s_cyc_o,
  output logic                                 s_stb_o,
  output logic                                 s_we_o,
  output logic [ADDR_WIDTH-1:0]                s_adr_o,
  output logic [DATA_WIDTH-1:0]                s_dat_o,
  output logic [DATA_WIDTH/8-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]                s_dat_i,
  input  logic                                 s_ack_i,
  input  logic                                 s_err_i,
  output logic [NUM_MASTERS-1:0]               grant_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDXW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, OWNED = 2'd1, ABORT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, OWNED = 2'd1} state_t;
`endif

  state_t                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  // last_q doubles as the owner index while a grant is held
  logic [IDXW-1:0]         last_q, last_d;
  logic [IDXW-1:0]         pick;
  logic [IDXW-1:0]         cand_idx;
  logic                    found;
  int                      own_i;
  logic                    own_cyc;
  logic                    own_stb;
  logic                    timeout;

  assign own_i   = int'(last_q);
  assign own_cyc = m_cyc_i[own_i];
  assign own_stb = m_stb_i[own_i];
  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        stall;

  // A same-cycle ack or err excludes the stall, so a real termination beats the watchdog
  assign stall   = (state_q == OWNED) && own_cyc && own_stb && !s_ack_i && !s_err_i;
  assign timeout = stall && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (stall && !timeout) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search upward from last+1 mod N
  always_comb begin
    found    = 1'b0;
    pick     = last_q;
    cand_idx = last_q;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand_idx = IDXW'((int'(last_q) + i) % NUM_MASTERS);
      if (!found && m_cyc_i[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
          state_d       = OWNED;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (timeout) begin
`ifdef WB_ARB_TIMEOUT_EN
          state_d = ABORT;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (!own_cyc) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Request/response muxing is combinational through the registered owner
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == OWNED) begin
      s_cyc_o        = own_cyc && !timeout;
      s_stb_o        = own_stb && !timeout;
      s_we_o         = m_we_i[own_i];
      s_adr_o        = m_adr_i[own_i*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o        = m_dat_i[own_i*DATA_WIDTH +: DATA_WIDTH];
      s_sel_o        = m_sel_i[own_i*SEL_W +: SEL_W];
      m_ack_o[own_i] = s_ack_i;
      m_err_o[own_i] = s_err_i || timeout;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Parametrised N-master to 1-slave WISHBONE classic arbiter for the SURF register space. It lets the serial boardman path, the TURF command path and future masters share one register bus without fixed priority. Ownership is granted round-robin and held for a whole `cyc` cycle. An optional watchdog terminates transactions that a slave never acknowledges.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of masters; valid range 2–8.
- `ADDR_WIDTH`, 22: address width.
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.
- `TIMEOUT_CYCLES`, 255: stalled-strobe cycles before abort. Used only with the macro in Configuration; valid range 2–65535.

Ports (N = `NUM_MASTERS`, AW = `ADDR_WIDTH`, DW = `DATA_WIDTH`):
- `wb_clk_i` in 1: the single clock.
- `wb_rst_n_i` in 1: asynchronous, active-low reset.
- `m_cyc_i` in N: per-master `cyc`.
- `m_stb_i` in N: per-master `stb`.
- `m_we_i` in N: per-master `we`.
- `m_adr_i` in N*AW: master k at `[k*AW +: AW]`.
- `m_dat_i` in N*DW: master k write data, packed the same way.
- `m_sel_i` in N*DW/8: master k byte selects, packed the same way.
- `m_dat_o` out DW: slave read data, broadcast to all masters.
- `m_ack_o` out N: ack, routed to the owner only.
- `m_err_o` out N: err, routed to the owner only.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave-side control.
- `s_adr_o` out AW: slave-side address.
- `s_dat_o` out DW: slave-side write data.
- `s_sel_o` out DW/8: slave-side byte selects.
- `s_dat_i` in DW: slave read data.
- `s_ack_i`, `s_err_i` in 1: slave termination.
- `grant_o` out N: one-hot registered owner; all zero when the bus is free.

## Operation
- The state machine has three states: IDLE, OWNED and ABORT. ABORT exists only with the macro.
- **IDLE**: if any `m_cyc_i` bit is high, pick the first requester searching upward from `last+1` mod N.
  - Register the choice into `grant_o` and `last`, and enter OWNED on the next edge.
  - With no requester, stay in IDLE with `grant_o` = 0.
- **OWNED**, owner k:
  - `s_cyc_o` = `m_cyc_i[k]` and `s_stb_o` = `m_stb_i[k]`.
  - `s_we_o`, `s_adr_o`, `s_dat_o` and `s_sel_o` are muxed from master k.
  - `m_ack_o[k]` = `s_ack_i` and `m_err_o[k]` = `s_err_i`; all other bits are 0.
  - Several strobes (a block transfer) may run under one `cyc`.
  - When `m_cyc_i[k]` falls, clear `grant_o` and return to IDLE. Re-arbitration happens in IDLE, so there is exactly one dead cycle between owners.
- Non-owners see `ack`/`err` = 0 and wait; their requests are never dropped.
- Whenever `grant_o` = 0, all `s_*` outputs are forced to 0.
- `m_dat_o` = `s_dat_i` at all times, unregistered.
- Simultaneous requests from all N masters are served in order `last+1`, `last+2`, …, so each master gets one `cyc` per N grants.
- Reset mid-transaction: every output returns to its reset value immediately and asynchronously. The slave sees `cyc` drop; masters must restart the transaction.

## Timing
- Reset values:
  - state = IDLE, `grant_o` = 0, `last` = N-1 (so master 0 wins first).
  - All `s_*` outputs = 0; `m_ack_o` and `m_err_o` = 0; timeout counter = 0.
- Grant latency: `m_cyc_i` rising while in IDLE gives `s_cyc_o` high on the following cycle.
- The slave-to-master `ack`/`err`/data path and the master-to-slave request path are combinational through a registered grant: zero added latency.
- Release: the owner's `cyc` low at edge t means `grant_o` = 0 after t. The next grant registers at edge t+1.

## Configuration
- Macro `WB_ARB_TIMEOUT_EN`, when defined:
  - A 16-bit counter increments on each OWNED cycle with `s_stb_o`=1, `s_ack_i`=0 and `s_err_i`=0.
  - The counter clears on `ack`, on `err`, on `stb` low, and on leaving OWNED.
  - When the counter reaches `TIMEOUT_CYCLES`:
    - Pulse `m_err_o[k]` for exactly one cycle.
    - Force `s_cyc_o` and `s_stb_o` to 0 from that cycle on.
    - Enter ABORT.
  - ABORT holds the grant with `s_*` = 0 until `m_cyc_i[k]` falls, then goes to IDLE.
  - A real `s_ack_i` arriving in the same cycle as the timeout wins: it is passed through as `ack`, with no `err` and no abort.
- Macro undefined: no counter and no ABORT state. `m_err_o` passes `s_err_i` only. A hung slave locks the bus until reset.

## Test plan
- Single master: master 1 reads address 0x000004 with `s_dat_i` = 0x00010001 and the slave acking in the same cycle. Required: `grant_o` = 0b10 one cycle after `cyc`; `m_ack_o` = 0b10; `m_dat_o` = 0x00010001; `m_ack_o[0]` stays 0.
- Contention, N = 2, both `cyc` raised together after reset. Required: master 0 is served first. After its `cyc` falls there is one idle cycle, then master 1 is served. A repeat with both still requesting serves master 0 next.
- Burst: master 0 holds `cyc` across 4 strobes. Required: `grant_o` stays 0b01 for all 4; master 1 is not granted until `cyc` falls.
- Timeout (`WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 10): the slave never acks. Required: exactly one `m_err_o` pulse on the 10th stalled cycle, then `s_cyc_o` = 0. Once the master drops `cyc`, the other master is granted normally.
- Reset: assert `wb_rst_n_i` low mid-burst. Required: `s_cyc_o` and `grant_o` go to 0 without waiting for a clock edge. After release, the first grant goes to master 0.
